// File: rtl/hello_scroller.sv
// hello_scroller: holds five character codes and a rotation offset. The
// offset advances on a prescaled timer (RUN) or one step per step_req
// rising edge (STOP). C0..C4 are the characters rotated by the offset.
module hello_scroller #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        load,
  input  logic [14:0] chars_in,
  input  logic        run,
  input  logic        dir,
  input  logic        step_req,
  output logic [2:0]  sel,
  output logic [2:0]  C0,
  output logic [2:0]  C1,
  output logic [2:0]  C2,
  output logic [2:0]  C3,
  output logic [2:0]  C4,
  output logic        tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  // char4..char0 = H E L L O
  localparam logic [4:0][2:0] HELLO = {3'b000, 3'b001, 3'b011, 3'b011, 3'b010};

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [4:0][2:0] char_q, char_d;
  logic [2:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            sreq_q;
  logic            do_step;
  logic [4:0][2:0] rot;

  // State register; step_req history is tracked in every state so a request
  // held through a RUN excursion cannot fire on the return to STOP.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      char_q  <= HELLO;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      sreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      sreq_q  <= step_req;
    end
  end

  // Next-state: mode FSM, prescaler, step decision; load overrides last.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    do_step = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (run) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
        if (step_req && !sreq_q) do_step = 1'b1;
      end
      ST_RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        if (!run) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          do_step = 1'b1;
        end
      end
    endcase
    if (do_step) begin
      tick_d = 1'b1;
      if (dir) sel_d = (sel_q == 3'd0) ? 3'd4 : sel_q - 3'd1;
      else     sel_d = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
    end
    // load discards any step due this cycle; state still follows run
    if (load) begin
      char_d = chars_in;
      sel_d  = 3'd0;
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  // Output rotation: Ci = char[(i - sel) mod 5]
  always_comb begin
    logic [3:0] idx;
    idx = 4'd0;
    rot = '0;
    for (int i = 0; i < 5; i++) begin
      idx = 4'(i) + 4'd5 - {1'b0, sel_q};
      if (idx >= 4'd5) idx = idx - 4'd5;
      rot[i] = char_q[idx[2:0]];
    end
  end

  assign sel  = sel_q;
  assign tick = tick_q;
  assign C0   = rot[0];
  assign C1   = rot[1];
  assign C2   = rot[2];
  assign C3   = rot[3];
  assign C4   = rot[4];

endmodule
